// File: rtl/df_activity_monitor_if.sv
// df_activity_monitor_if: control, handshake, stall and read-port signals of the activity monitor
interface df_activity_monitor_if #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 32
);
  logic              mon_en;
  logic              mon_clr;
  logic [NUM_CH-1:0] ch_start;
  logic [NUM_CH-1:0] ch_ready;
  logic [NUM_CH-1:0] ch_done;
  logic [NUM_CH-1:0] ch_continue;
  logic [NUM_CH-1:0] ch_in_stall;
  logic [NUM_CH-1:0] ch_out_stall;
  logic              rd_req;
  logic [4:0]        rd_ch;
  logic [1:0]        rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] ch_busy;
  logic              hang;
  logic [NUM_CH-1:0] hang_ch;
  modport master (
    output mon_en, mon_clr, ch_start, ch_ready, ch_done, ch_continue, ch_in_stall, ch_out_stall,
    output rd_req, rd_ch, rd_sel,
    input  rd_valid, rd_data, ch_busy, hang, hang_ch
  );
  modport slave (
    input  mon_en, mon_clr, ch_start, ch_ready, ch_done, ch_continue, ch_in_stall, ch_out_stall,
    input  rd_req, rd_ch, rd_sel,
    output rd_valid, rd_data, ch_busy, hang, hang_ch
  );
endinterface

// File: rtl/df_activity_monitor.sv
// df_activity_monitor: per-process dataflow handshake statistics with a no-progress hang watchdog
module df_activity_monitor #(
  parameter int NUM_CH     = 8,
  parameter int CNT_W      = 32,
  parameter int WDOG_W     = 16,
  parameter int WDOG_LIMIT = 4096
) (
  input logic ap_clk,
  input logic ap_rst_n,
  df_activity_monitor_if.slave mon
);
  typedef enum logic [1:0] {IDLE, RUN, DONE_WAIT} state_t;
  state_t            state     [NUM_CH];
  state_t            state_nxt [NUM_CH];
  logic [CNT_W-1:0]  cnt       [NUM_CH][4];
  logic [3:0]        inc       [NUM_CH];
  logic [NUM_CH-1:0] fin;
  logic [WDOG_W-1:0] wdog;
  logic              progress;
  logic [CNT_W-1:0]  rd_mux;
  always_comb begin
    fin = mon.ch_done & mon.ch_continue;
    progress = |(mon.ch_ready | fin);
    mon.ch_busy = '0;
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mon.ch_busy[i] = state[i] != IDLE;
      state_nxt[i] = state[i] == IDLE ? (mon.ch_start[i] ? RUN : IDLE)
                   : state[i] == RUN  ? (!mon.ch_done[i] ? RUN : !mon.ch_continue[i] ? DONE_WAIT : mon.ch_start[i] ? RUN : IDLE)
                   : (!mon.ch_continue[i] ? DONE_WAIT : mon.ch_start[i] ? RUN : IDLE);
      // counter order matches rd_sel: active, in_stall, out_stall, transactions
      inc[i] = {fin[i], state[i] == RUN && mon.ch_out_stall[i], state[i] == RUN && mon.ch_in_stall[i], state[i] != IDLE};
      if (mon.rd_ch == 5'(i)) rd_mux = cnt[i][mon.rd_sel];
    end
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= IDLE;
        for (int k = 0; k < 4; k++) cnt[i][k] <= '0;
      end
      wdog         <= '0;
      mon.hang     <= 1'b0;
      mon.hang_ch  <= '0;
      mon.rd_valid <= 1'b0;
      mon.rd_data  <= '0;
    end else begin
      mon.rd_valid <= mon.rd_req;
      mon.rd_data  <= mon.rd_req ? rd_mux : '0;
      if (mon.mon_clr) begin
        for (int i = 0; i < NUM_CH; i++) begin
          state[i] <= IDLE;
          for (int k = 0; k < 4; k++) cnt[i][k] <= '0;
        end
        wdog        <= '0;
        mon.hang    <= 1'b0;
        mon.hang_ch <= '0;
      end else if (mon.mon_en) begin
        for (int i = 0; i < NUM_CH; i++) begin
          state[i] <= state_nxt[i];
          for (int k = 0; k < 4; k++)
            if (!mon.hang && inc[i][k] && cnt[i][k] != '1) cnt[i][k] <= cnt[i][k] + 1'b1;
        end
        if (progress || mon.ch_busy == '0) wdog <= '0;
        else if (!mon.hang) begin
          wdog <= wdog + 1'b1;
          if (wdog == WDOG_W'(WDOG_LIMIT - 1)) begin
            mon.hang    <= 1'b1;
            mon.hang_ch <= mon.ch_busy;
          end
        end
      end
    end
endmodule

// File: tb/tb_df_activity_monitor.sv
// tb_df_activity_monitor: directed, table-driven and randomized checks against a behavioural model
module tb_df_activity_monitor;
  localparam int NCH = 8;
  localparam int SAT = 15;
  localparam int LIM = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  df_activity_monitor_if #(.NUM_CH(NCH), .CNT_W(4)) b();
  df_activity_monitor #(.NUM_CH(NCH), .CNT_W(4), .WDOG_W(5), .WDOG_LIMIT(LIM)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .mon(b)
  );
  always #5 clk = ~clk;
  int       m_cnt [NCH][4];
  bit       m_run [NCH];
  bit       m_wait[NCH];
  int       m_stuck;
  bit       m_hang;
  bit [7:0] m_hang_ch;
  typedef struct { int ch; int sel; int exp; } rd_vec_t;
  rd_vec_t tbl [12];
  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 0;
      m_wait[c] = 0;
      for (int k = 0; k < 4; k++) m_cnt[c][k] = 0;
    end
    m_stuck = 0;
    m_hang = 0;
    m_hang_ch = 0;
  endtask
  function automatic bit [7:0] m_busy();
    bit [7:0] v = 0;
    for (int c = 0; c < NCH; c++) v[c] = m_run[c] | m_wait[c];
    return v;
  endfunction
  function automatic int m_read(int ch, int sel);
    return ch < NCH ? m_cnt[ch][sel] : 0;
  endfunction
  task automatic bump(int c, int k);
    if (m_cnt[c][k] < SAT) m_cnt[c][k]++;
  endtask
  task automatic model_step();
    bit [7:0] busy = m_busy();
    bit prog = 0;
    if (b.mon_clr) begin
      model_reset();
      return;
    end
    if (!b.mon_en) return;
    for (int c = 0; c < NCH; c++) begin
      bit fin = b.ch_done[c] & b.ch_continue[c];
      if (fin || b.ch_ready[c]) prog = 1;
      if (!m_hang) begin
        if (busy[c]) bump(c, 0);
        if (m_run[c] && b.ch_in_stall[c]) bump(c, 1);
        if (m_run[c] && b.ch_out_stall[c]) bump(c, 2);
        if (fin) bump(c, 3);
      end
      if (m_run[c]) begin
        if (b.ch_done[c]) begin
          m_wait[c] = !b.ch_continue[c];
          m_run[c] = b.ch_continue[c] & b.ch_start[c];
        end
      end else if (m_wait[c]) begin
        if (b.ch_continue[c]) begin
          m_wait[c] = 0;
          m_run[c] = b.ch_start[c];
        end
      end else m_run[c] = b.ch_start[c];
    end
    if (prog || busy == 0) m_stuck = 0;
    else if (!m_hang) begin
      m_stuck++;
      if (m_stuck == LIM) begin
        m_hang = 1;
        m_hang_ch = busy;
      end
    end
  endtask
  task automatic tick();
    bit ev = b.rd_req;
    int ed = b.rd_req ? m_read(int'(b.rd_ch), int'(b.rd_sel)) : 0;
    model_step();
    @(posedge clk);
    #1;
    check("rd_valid", 32'(b.rd_valid), 32'(ev));
    check("rd_data", 32'(b.rd_data), ed);
    check("ch_busy", 32'(b.ch_busy), 32'(m_busy()));
    check("hang", 32'(b.hang), 32'(m_hang));
    check("hang_ch", 32'(b.hang_ch), 32'(m_hang_ch));
  endtask
  task automatic idle_inputs();
    b.mon_clr = 0;
    b.ch_start = 0;
    b.ch_ready = 0;
    b.ch_done = 0;
    b.ch_continue = 0;
    b.ch_in_stall = 0;
    b.ch_out_stall = 0;
    b.rd_req = 0;
    b.rd_ch = 0;
    b.rd_sel = 0;
  endtask
  task automatic read(int ch, int sel, int want, string name);
    b.rd_req = 1;
    b.rd_ch = 5'(ch);
    b.rd_sel = 2'(sel);
    tick();
    check(name, 32'(b.rd_data), want);
    b.rd_req = 0;
  endtask
  initial begin
    tbl = '{'{0, 0, 11}, '{0, 3, 1}, '{0, 1, 0}, '{1, 0, 10}, '{1, 3, 1}, '{1, 1, 0},
            '{2, 0, 11}, '{2, 1, 7}, '{2, 2, 3}, '{2, 3, 1}, '{9, 0, 0}, '{31, 3, 0}};
    idle_inputs();
    b.mon_en = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(b.ch_busy), 0);
    check("rst_hang", 32'(b.hang), 0);
    check("rst_hang_ch", 32'(b.hang_ch), 0);
    check("rst_rd_valid", 32'(b.rd_valid), 0);
    check("rst_rd_data", 32'(b.rd_data), 0);
    rst_n = 1;
    // ch0 plain run, ch1 with a 4-cycle continue hold-off, ch2 with stalls
    for (int c = 0; c < 12; c++) begin
      b.ch_start = (c == 0) ? 8'h07 : 8'h00;
      b.ch_done = {5'b0, c == 11, c >= 6 && c <= 10, c == 11};
      b.ch_continue = {5'b0, c == 11, c == 10, c == 11};
      b.ch_in_stall = {5'b0, c >= 1 && c <= 7, 2'b0};
      b.ch_out_stall = {5'b0, c >= 8 && c <= 10, 2'b0};
      tick();
      if (c == 6) check("busy_mid", 32'(b.ch_busy), 32'h07);
    end
    idle_inputs();
    tick();
    check("busy_after", 32'(b.ch_busy), 0);
    b.mon_en = 0;
    for (int i = 0; i < 12; i++) read(tbl[i].ch, tbl[i].sel, tbl[i].exp, $sformatf("tbl%0d", i));
    b.mon_en = 1;
    b.mon_clr = 1;
    tick();
    b.mon_clr = 0;
    read(0, 3, 0, "clr_trans");
    // ch0 busy 20 cycles while ch7 keeps signalling progress
    for (int c = 0; c < 22; c++) begin
      b.ch_start = (c == 0) ? 8'h01 : 8'h00;
      b.ch_ready = 8'h80;
      b.ch_done = (c == 21) ? 8'h01 : 8'h00;
      b.ch_continue = (c == 21) ? 8'h01 : 8'h00;
      tick();
    end
    idle_inputs();
    read(0, 0, SAT, "sat_active");
    read(0, 3, 1, "sat_trans");
    b.mon_clr = 1;
    tick();
    b.mon_clr = 0;
    read(0, 0, 0, "sat_clr");
    // ch3 stuck with no progress
    for (int c = 0; c < 22; c++) begin
      b.ch_start = (c == 0) ? 8'h08 : 8'h00;
      b.ch_in_stall = (c >= 10 && c <= 20) ? 8'h08 : 8'h00;
      b.ch_done = (c == 21) ? 8'h08 : 8'h00;
      b.ch_continue = (c == 21) ? 8'h08 : 8'h00;
      tick();
      if (c == 15) check("hang_early", 32'(b.hang), 0);
      if (c == 16) begin
        check("hang_set", 32'(b.hang), 1);
        check("hang_ch_set", 32'(b.hang_ch), 32'h08);
      end
    end
    idle_inputs();
    read(3, 1, 7, "frozen_in_stall");
    read(3, 3, 0, "frozen_trans");
    read(3, 0, SAT, "frozen_active");
    check("hang_sticky", 32'(b.hang), 1);
    b.mon_clr = 1;
    tick();
    b.mon_clr = 0;
    check("hang_clr", 32'(b.hang), 0);
    // async reset in the middle of activity
    for (int c = 0; c < 4; c++) begin
      b.ch_start = (c == 0) ? 8'h03 : 8'h00;
      b.ch_ready = 8'h80;
      b.rd_req = 1;
      b.rd_ch = 0;
      tick();
    end
    idle_inputs();
    #3 rst_n = 0;
    #1;
    check("arst_busy", 32'(b.ch_busy), 0);
    check("arst_rd_valid", 32'(b.rd_valid), 0);
    check("arst_rd_data", 32'(b.rd_data), 0);
    check("arst_hang", 32'(b.hang), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    read(0, 0, 0, "arst_active");
    read(1, 0, 0, "arst_active1");
    for (int n = 0; n < 800; n++) begin
      b.mon_en = ($urandom_range(0, 7) != 0);
      b.mon_clr = ($urandom_range(0, 49) == 0);
      b.ch_start = 8'($urandom & $urandom);
      b.ch_ready = 8'($urandom & $urandom & $urandom & $urandom);
      b.ch_done = 8'($urandom & $urandom);
      b.ch_continue = 8'($urandom);
      b.ch_in_stall = 8'($urandom);
      b.ch_out_stall = 8'($urandom);
      b.rd_req = 1'($urandom);
      b.rd_ch = 5'($urandom_range(0, 10));
      b.rd_sel = 2'($urandom);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
